kernel5_result_writer: RTL and testbench

KERNEL5_RESULT_WRITER -- requirements
Module: kernel5_result_writer

---
 rtl/kernel5_result_writer.sv | 116 +++++++++++
 tb/tb_kernel5_result_writer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/kernel5_result_writer.sv
// Writes valid 5x5 filter results (columns >= 4 of each row) to a linear output memory.
// Optional macro KERNEL5_WRITER_SAT_EN clamps results to [0, 2^Datawidth-1] instead of truncating.
module kernel5_result_writer #(
    parameter int IMG_Width  = 8,
    parameter int IMG_Height = 8,
    parameter int Datawidth  = 8,
    parameter int AddrWidth  = 16
) (
    input  logic                   CLK,
    input  logic                   CLR,
    input  logic                   Start,
    input  logic                   Valid_IN,
    input  logic [Datawidth+3:0]   In,
    output logic                   Mem_WE,
    output logic [AddrWidth-1:0]   Mem_Addr,
    output logic [Datawidth-1:0]   Mem_Data,
    output logic                   Busy,
    output logic                   Done
);

    localparam int CW = $clog2(IMG_Width);
    localparam int RW = $clog2(IMG_Height);
    localparam logic [CW-1:0] COL_FIRST = CW'(4);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_Width - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_Height - 5);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state, state_next;
    logic [CW-1:0]          col;
    logic [RW-1:0]          row;
    logic [AddrWidth-1:0]   addr_cnt;
    logic                   accept;
    logic                   last_pix;
    logic [Datawidth-1:0]   store_data;

    always_comb begin
        accept   = (state == RUN) && Valid_IN && (col >= COL_FIRST);
        last_pix = accept && (row == ROW_LAST) && (col == COL_LAST);
    end

`ifdef KERNEL5_WRITER_SAT_EN
    always_comb begin
        if (In[Datawidth+3])
            store_data = '0;
        else if (|In[Datawidth+2:Datawidth])
            store_data = '1;
        else
            store_data = In[Datawidth-1:0];
    end
`else
    always_comb begin
        store_data = In[Datawidth-1:0];
    end
`endif

    always_ff @(posedge CLK) begin
        if (CLR)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start) state_next = RUN;
            RUN:     if (last_pix) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Accepted samples arrive in raster order, so the write address is a plain
    // running count: Row*(IMG_Width-4)+(Col-4) without a multiplier.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            col      <= '0;
            row      <= '0;
            addr_cnt <= '0;
        end else if (state == IDLE && Start) begin
            col      <= '0;
            row      <= '0;
            addr_cnt <= '0;
        end else if (state == RUN && Valid_IN) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
            if (accept)
                addr_cnt <= addr_cnt + AddrWidth'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            Mem_WE   <= 1'b0;
            Mem_Addr <= '0;
            Mem_Data <= '0;
        end else begin
            Mem_WE <= accept;
            if (accept) begin
                Mem_Addr <= addr_cnt;
                Mem_Data <= store_data;
            end
        end
    end

    always_comb begin
        Busy = (state == RUN);
        Done = (state == DONE);
    end

endmodule

// File: tb/tb_kernel5_result_writer.sv
// Randomized bench for kernel5_result_writer against a sample-index reference model.
// Expected stored data follows KERNEL5_WRITER_SAT_EN when defined.
module tb_kernel5_result_writer;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int NPIX = (W - 4) * (H - 4);

    logic          CLK = 1'b0;
    logic          CLR = 1'b0;
    logic          Start = 1'b0;
    logic          Valid_IN = 1'b0;
    logic [DW+3:0] In = '0;
    logic          Mem_WE;
    logic [AW-1:0] Mem_Addr;
    logic [DW-1:0] Mem_Data;
    logic          Busy;
    logic          Done;

    kernel5_result_writer #(
        .IMG_Width (W),
        .IMG_Height(H),
        .Datawidth (DW),
        .AddrWidth (AW)
    ) dut (
        .CLK     (CLK),
        .CLR     (CLR),
        .Start   (Start),
        .Valid_IN(Valid_IN),
        .In      (In),
        .Mem_WE  (Mem_WE),
        .Mem_Addr(Mem_Addr),
        .Mem_Data(Mem_Data),
        .Busy    (Busy),
        .Done    (Done)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model: a frame is a sequence of valid samples indexed k;
    // sample k sits at column k%W, row k/W and is stored only if column >= 4.
    bit m_run  = 1'b0;
    bit m_done = 1'b0;
    int k      = 0;
    bit exp_we = 1'b0;
    int exp_addr = 0;
    int exp_data = 0;
    int m_writes = 0;
    int dut_writes = 0;
    int done_seen  = 0;

    function automatic int stored(input int v);
`ifdef KERNEL5_WRITER_SAT_EN
        if (v < 0) return 0;
        if (v > (1 << DW) - 1) return (1 << DW) - 1;
        return v;
`else
        return v & ((1 << DW) - 1);
`endif
    endfunction

    function automatic int rnd_in();
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    task automatic check(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step(input bit clr, input bit st, input bit vld, input int v);
        bit was_done;
        int c, r;
        CLR      = clr;
        Start    = st;
        Valid_IN = vld;
        In       = 12'(v);
        @(posedge CLK);
        #1;
        if (clr) begin
            m_run = 0; m_done = 0; k = 0;
            exp_we = 0; exp_addr = 0; exp_data = 0;
        end else begin
            was_done = m_done;
            m_done   = 0;
            exp_we   = 0;
            if (m_run && vld) begin
                c = k % W;
                r = k / W;
                k++;
                if (c >= 4) begin
                    exp_we   = 1;
                    exp_addr = r * (W - 4) + (c - 4);
                    exp_data = stored(v);
                    m_writes++;
                    if (exp_addr == NPIX - 1) begin
                        m_run  = 0;
                        m_done = 1;
                    end
                end
            end else if (!m_run && !was_done && st) begin
                m_run = 1;
                k     = 0;
            end
        end
        dut_writes += int'(Mem_WE);
        done_seen  += int'(Done);
        check("we",   int'(Mem_WE),   int'(exp_we));
        check("addr", int'(Mem_Addr), exp_addr);
        check("data", int'(Mem_Data), exp_data);
        check("busy", int'(Busy),     int'(m_run));
        check("done", int'(Done),     int'(m_done));
    endtask

    task automatic frame_reset_counts();
        dut_writes = 0;
        done_seen  = 0;
        m_writes   = 0;
    endtask

    initial begin
        int v;
        int guard;

        // Reset, with Start/Valid asserted to confirm CLR priority
        step(1, 1, 1, 5);
        step(1, 0, 0, 0);

        // Valid pulses while idle must not write
        frame_reset_counts();
        for (int i = 0; i < 4; i++) step(0, 0, 1, rnd_in());
        check("idle_writes", dut_writes, 0);

        // Frame 1: 32 back-to-back samples, directed data at first three outputs
        frame_reset_counts();
        step(0, 1, 0, 0);
        for (int i = 0; i < 32; i++) begin
            v = (i == 4) ? -3 : (i == 5) ? 300 : (i == 6) ? 77 : rnd_in();
            step(0, 0, 1, v);
        end
        step(0, 0, 1, rnd_in());
        step(0, 0, 0, 0);
        check("f1_writes", dut_writes, NPIX);
        check("f1_done",   done_seen, 1);

        // Frame 2: Valid_IN toggling every cycle
        frame_reset_counts();
        step(0, 1, 0, 0);
        for (int i = 0; i < 64; i++) step(0, 0, (i % 2) == 0, rnd_in());
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("f2_writes", dut_writes, NPIX);
        check("f2_done",   done_seen, 1);

        // Frame 3: stray Start after 10 samples, then Start right after Done
        frame_reset_counts();
        step(0, 1, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, rnd_in());
        step(0, 1, 1, rnd_in());
        for (int i = 0; i < 21; i++) step(0, 0, 1, rnd_in());
        check("f3_writes", dut_writes, NPIX);
        check("f3_done",   done_seen, 1);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);

        // Frame 4: random gaps, abort with CLR after the 6th write
        frame_reset_counts();
        guard = 0;
        while (m_writes < 6 && guard < 400) begin
            step(0, 0, $urandom_range(0, 1) == 1, rnd_in());
            guard++;
        end
        check("f4_reached_6", m_writes, 6);
        step(1, 1, 1, rnd_in());
        for (int i = 0; i < 8; i++) step(0, 0, 1, rnd_in());
        check("f4_writes", dut_writes, 6);
        check("f4_done",   done_seen, 0);

        // Frame 5: full frame with random gaps after the abort
        frame_reset_counts();
        step(0, 1, 0, 0);
        guard = 0;
        while (!m_done && guard < 800) begin
            step(0, 0, $urandom_range(0, 2) != 0, rnd_in());
            guard++;
        end
        check("f5_finished", int'(m_done), 1);
        step(0, 0, 1, rnd_in());
        step(0, 0, 0, 0);
        check("f5_writes", dut_writes, NPIX);
        check("f5_done",   done_seen, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
